// File: rtl/ixu_pkg.sv
// Shared integer-unit definitions.
// Register-file geometry, address type and a one-hot decode helper.
package ixu_pkg;

   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_LANES  = 2;
   localparam int NUM_RS     = 4;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   function automatic logic [NUM_REGS-1:0] rd_dec(
      input reg_addr_t a,
      input logic      en
   );
      logic [NUM_REGS-1:0] m;
      m    = '0;
      m[a] = en;
      return m;
   endfunction

endpackage

// File: rtl/ixu_scoreboard.sv
// Busy scoreboard for in-flight register writes.
// Issue sets, commit clears; a same-cycle issue wins over a commit.
module ixu_scoreboard
   import ixu_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      stall,
   input  logic      cmt0,
   input  logic      cmt1,
   input  reg_addr_t cmt0_rd,
   input  reg_addr_t cmt1_rd,
   input  logic      iss0_valid,
   input  logic      iss1_valid,
   input  reg_addr_t iss0_rd,
   input  reg_addr_t iss1_rd,
   input  reg_addr_t rs_addr [NUM_RS],
   output logic      rs_busy [NUM_RS]
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] set_m;
   logic [NUM_REGS-1:0] clr_m;
   logic                iss0_en;
   logic                iss1_en;

   assign iss0_en = !rst && !stall && iss0_valid && (iss0_rd != '0);
   assign iss1_en = !rst && !stall && iss1_valid && (iss1_rd != '0);

   assign set_m = rd_dec(iss0_rd, iss0_en) | rd_dec(iss1_rd, iss1_en);
   assign clr_m = rd_dec(cmt0_rd, cmt0) | rd_dec(cmt1_rd, cmt1);

   // Scoreboard update; entry 0 is never set so it stays 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~clr_m) | set_m;
      end
   end

   // Busy lookup that already sees this cycle's commits.
   always_comb begin
      for (int i = 0; i < NUM_RS; i++) begin
         rs_busy[i] = busy[rs_addr[i]]
                    & ~(clr_m[rs_addr[i]] & ~set_m[rs_addr[i]]);
      end
   end

endmodule

// File: rtl/ixu_wb_regfile.sv
// Dual-lane writeback register file with zero-cycle bypass.
// Lane 1 is the later slot, so it wins on a same-rd collision.
module ixu_wb_regfile
   import ixu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            wb0_is_nop,
   input  logic            wb1_is_nop,
   input  reg_addr_t       wb0_rd,
   input  reg_addr_t       wb1_rd,
   input  logic [XLEN-1:0] wb0_data,
   input  logic [XLEN-1:0] wb1_data,
   input  logic            iss0_valid,
   input  logic            iss1_valid,
   input  reg_addr_t       iss0_rd,
   input  reg_addr_t       iss1_rd,
   input  reg_addr_t       rs_addr [NUM_RS],
   output logic [XLEN-1:0] rs_data [NUM_RS],
   output logic            rs_busy [NUM_RS],
   output logic [XLEN-1:0] retire_count
);

   logic [XLEN-1:0] regs [NUM_REGS];
   logic            ret0;
   logic            ret1;
   logic            cmt0;
   logic            cmt1;
   logic [1:0]      n_ret;

   // rd=0 still retires, but only a nonzero rd writes and bypasses.
   assign ret0  = !rst && !stall && !wb0_is_nop;
   assign ret1  = !rst && !stall && !wb1_is_nop;
   assign cmt0  = ret0 && (wb0_rd != '0);
   assign cmt1  = ret1 && (wb1_rd != '0);
   assign n_ret = {1'b0, ret0} + {1'b0, ret1};

   // Storage write; lane 1 assigned last so it takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (cmt0) regs[wb0_rd] <= wb0_data;
         if (cmt1) regs[wb1_rd] <= wb1_data;
      end
   end

   // Retired-writeback counter, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_count <= '0;
      end else begin
         retire_count <= retire_count + XLEN'(n_ret);
      end
   end

   // Read ports with same-cycle bypass, lane 1 checked first.
   always_comb begin
      for (int i = 0; i < NUM_RS; i++) begin
         if (cmt1 && (wb1_rd == rs_addr[i])) begin
            rs_data[i] = wb1_data;
         end else if (cmt0 && (wb0_rd == rs_addr[i])) begin
            rs_data[i] = wb0_data;
         end else begin
            rs_data[i] = regs[rs_addr[i]];
         end
      end
   end

   ixu_scoreboard u_sb (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .cmt0       (cmt0),
      .cmt1       (cmt1),
      .cmt0_rd    (wb0_rd),
      .cmt1_rd    (wb1_rd),
      .iss0_valid (iss0_valid),
      .iss1_valid (iss1_valid),
      .iss0_rd    (iss0_rd),
      .iss1_rd    (iss1_rd),
      .rs_addr    (rs_addr),
      .rs_busy    (rs_busy)
   );

endmodule

// File: tb/tb_ixu_wb_regfile.sv
// Directed bench for ixu_wb_regfile.
// Hand-computed expectations for bypass, priority, stall, scoreboard, reset.
module tb_ixu_wb_regfile;
   import ixu_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall;
   logic            wb0_is_nop;
   logic            wb1_is_nop;
   reg_addr_t       wb0_rd;
   reg_addr_t       wb1_rd;
   logic [XLEN-1:0] wb0_data;
   logic [XLEN-1:0] wb1_data;
   logic            iss0_valid;
   logic            iss1_valid;
   reg_addr_t       iss0_rd;
   reg_addr_t       iss1_rd;
   reg_addr_t       rs_addr [NUM_RS];
   logic [XLEN-1:0] rs_data [NUM_RS];
   logic            rs_busy [NUM_RS];
   logic [XLEN-1:0] retire_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ixu_wb_regfile dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .wb0_is_nop   (wb0_is_nop),
      .wb1_is_nop   (wb1_is_nop),
      .wb0_rd       (wb0_rd),
      .wb1_rd       (wb1_rd),
      .wb0_data     (wb0_data),
      .wb1_data     (wb1_data),
      .iss0_valid   (iss0_valid),
      .iss1_valid   (iss1_valid),
      .iss0_rd      (iss0_rd),
      .iss1_rd      (iss1_rd),
      .rs_addr      (rs_addr),
      .rs_data      (rs_data),
      .rs_busy      (rs_busy),
      .retire_count (retire_count)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      stall      = 1'b0;
      wb0_is_nop = 1'b1;
      wb1_is_nop = 1'b1;
      wb0_rd     = '0;
      wb1_rd     = '0;
      wb0_data   = '0;
      wb1_data   = '0;
      iss0_valid = 1'b0;
      iss1_valid = 1'b0;
      iss0_rd    = '0;
      iss1_rd    = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      for (int i = 0; i < NUM_RS; i++) rs_addr[i] = '0;
      rst = 1'b1;
      #3;
      chk("rst_count", retire_count, 32'd0);
      chk("rst_data0", rs_data[0], 32'd0);
      chk("rst_busy0", 32'(rs_busy[0]), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Lane 0 write with same-cycle bypass.
      rs_addr[2] = 5'd5;
      wb0_is_nop = 1'b0;
      wb0_rd     = 5'd5;
      wb0_data   = 32'hDEADBEEF;
      #1;
      chk("byp_x5", rs_data[2], 32'hDEADBEEF);
      tick();
      idle();
      #1;
      chk("store_x5", rs_data[2], 32'hDEADBEEF);
      chk("count_1", retire_count, 32'd1);

      // Both lanes to x7: lane 1 wins.
      rs_addr[0] = 5'd7;
      wb0_is_nop = 1'b0;
      wb0_rd     = 5'd7;
      wb0_data   = 32'h1111;
      wb1_is_nop = 1'b0;
      wb1_rd     = 5'd7;
      wb1_data   = 32'h2222;
      #1;
      chk("byp_x7", rs_data[0], 32'h2222);
      tick();
      idle();
      #1;
      chk("store_x7", rs_data[0], 32'h2222);
      chk("count_3", retire_count, 32'd3);

      // Held commit under stall retires once.
      rs_addr[1] = 5'd3;
      wb0_is_nop = 1'b0;
      wb0_rd     = 5'd3;
      wb0_data   = 32'h55;
      tick();
      stall = 1'b1;
      tick();
      tick();
      tick();
      #1;
      chk("stall_count", retire_count, 32'd4);
      chk("stall_x3", rs_data[1], 32'h55);
      idle();
      #1;

      // Scoreboard: re-issue beats commit.
      rs_addr[3] = 5'd9;
      iss0_valid = 1'b1;
      iss0_rd    = 5'd9;
      tick();
      idle();
      #1;
      chk("busy_set", 32'(rs_busy[3]), 32'd1);
      tick();
      wb1_is_nop = 1'b0;
      wb1_rd     = 5'd9;
      wb1_data   = 32'h99;
      iss0_valid = 1'b1;
      iss0_rd    = 5'd9;
      #1;
      chk("busy_reiss_c", 32'(rs_busy[3]), 32'd1);
      chk("byp_x9", rs_data[3], 32'h99);
      tick();
      idle();
      #1;
      chk("busy_reiss_r", 32'(rs_busy[3]), 32'd1);
      wb0_is_nop = 1'b0;
      wb0_rd     = 5'd9;
      wb0_data   = 32'h9A;
      #1;
      chk("busy_clr_c", 32'(rs_busy[3]), 32'd0);
      tick();
      idle();
      #1;
      chk("busy_clr_r", 32'(rs_busy[3]), 32'd0);
      chk("store_x9", rs_data[3], 32'h9A);
      chk("count_6", retire_count, 32'd6);

      // x0 is immutable but the write still retires.
      for (int i = 0; i < NUM_RS; i++) rs_addr[i] = '0;
      wb0_is_nop = 1'b0;
      wb0_rd     = '0;
      wb0_data   = 32'hFFFFFFFF;
      iss1_valid = 1'b1;
      iss1_rd    = '0;
      #1;
      for (int i = 0; i < NUM_RS; i++) begin
         chk($sformatf("x0_byp%0d", i), rs_data[i], 32'd0);
      end
      tick();
      idle();
      #1;
      chk("x0_store", rs_data[2], 32'd0);
      chk("x0_busy", 32'(rs_busy[1]), 32'd0);
      chk("count_7", retire_count, 32'd7);

      // Lane 1 bypass priority over storage on a different port.
      rs_addr[1] = 5'd3;
      wb1_is_nop = 1'b0;
      wb1_rd     = 5'd3;
      wb1_data   = 32'hCAFE;
      #1;
      chk("byp_l1_x3", rs_data[1], 32'hCAFE);
      tick();
      idle();

      // Mid-cycle asynchronous reset.
      rs_addr[0] = 5'd7;
      rs_addr[2] = 5'd5;
      rs_addr[3] = 5'd12;
      iss0_valid = 1'b1;
      iss0_rd    = 5'd12;
      tick();
      idle();
      #1;
      chk("busy_x12", 32'(rs_busy[3]), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_x7", rs_data[0], 32'd0);
      chk("arst_x5", rs_data[2], 32'd0);
      chk("arst_busy", 32'(rs_busy[3]), 32'd0);
      chk("arst_count", retire_count, 32'd0);

      // Commit presented as reset drops before the edge proceeds.
      #1;
      rst        = 1'b0;
      rs_addr[1] = 5'd4;
      wb0_is_nop = 1'b0;
      wb0_rd     = 5'd4;
      wb0_data   = 32'hA5;
      tick();
      idle();
      #1;
      chk("post_rst_x4", rs_data[1], 32'hA5);
      chk("post_rst_cnt", retire_count, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
